// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Mealy serial-pattern detector with KMP fallback
// and a saturating match counter.
module seq_detector_param #(
  parameter int                 SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0] PATTERN = 3'b101,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int              SW   = $clog2(SEQ_LEN);
  localparam logic [SW-1:0]   LAST = SW'(SEQ_LEN - 1);
  localparam logic [SW:0]     LEN  = (SW + 1)'(SEQ_LEN);
  // Longest suffix of (first k pattern bits, b) that is a proper pattern prefix;
  // on a full match this is exactly the KMP failure value.
  function automatic int nxt(int k, logic b);
    int   r;
    logic ok;
    logic sb;
    r = 0;
    for (int l = 1; l <= k + 1 && l < SEQ_LEN; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        sb = (k + 1 - l + j == k) ? b : PATTERN[SEQ_LEN - 1 - (k + 1 - l + j)];
        if (sb != PATTERN[SEQ_LEN - 1 - j]) ok = 1'b0;
      end
      if (ok) r = l;
    end
    return r;
  endfunction
  logic [SEQ_LEN-1:0] pr;
  logic [SW-1:0]      nx0 [SEQ_LEN];
  logic [SW-1:0]      nx1 [SEQ_LEN];
  logic [SW-1:0]      state_q, state_d, k, nx;
  logic               exp;
  for (genvar i = 0; i < SEQ_LEN; i++) begin : g_tbl
    assign pr[i]  = PATTERN[SEQ_LEN-1-i];
    assign nx0[i] = SW'(nxt(i, 1'b0));
    assign nx1[i] = SW'(nxt(i, 1'b1));
  end
  always_comb begin
    k       = ({1'b0, state_q} < LEN) ? state_q : '0;
    exp     = pr[k];
    y       = en & (k == LAST) & (x == exp) & !rst;
    nx      = x ? nx1[k] : nx0[k];
    state_d = !en ? k : (y && !overlap) ? '0 : nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      match_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clr_cnt) match_cnt <= '0;
      else if (y && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
    end
  end
endmodule
